// File: rtl/io_port_ctrl.sv
// io_port_ctrl: sequences execute-stage IN/OUT instructions against external byte ports,
// holding the pipeline stalled until the device handshake completes or the wait times out.
module io_port_ctrl #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_in_req,
  input  logic              ex_out_req,
  input  logic [DATA_W-1:0] ex_out_data,
  output logic [DATA_W-1:0] in_data,
  output logic              io_stall,
  output logic              io_done,
  output logic              io_timeout,
  input  logic              clr_err,
  input  logic              port_in_valid,
  input  logic [DATA_W-1:0] port_in_data,
  output logic              port_in_ack,
  output logic              port_out_valid,
  output logic [DATA_W-1:0] port_out_data,
  input  logic              port_out_ready
);

  // With TIMEOUT=0 the counter is never consulted; keep it one bit wide so it stays legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, IN_WAIT, OUT_WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              timeout_q, timeout_d;
  logic              hs, expire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      in_data_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      in_data_q   <= in_data_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ack_d       = ack_q;
    in_data_d   = in_data_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    timeout_d   = timeout_q;
    hs          = 1'b0;
    expire      = 1'b0;

    case (state_q)
      IDLE: begin
        ack_d = 1'b0;
        cnt_d = '0;
        if (ex_in_req) begin
          state_d = IN_WAIT;
        end else if (ex_out_req) begin
          state_d     = OUT_WAIT;
          out_data_d  = ex_out_data;
          out_valid_d = 1'b1;
        end
      end
      IN_WAIT, OUT_WAIT: begin
        hs     = (state_q == IN_WAIT) ? port_in_valid : (out_valid_q && port_out_ready);
        expire = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
        // A handshake landing on the final wait cycle still counts as a clean transfer.
        if (hs) begin
          state_d = DONE;
          if (state_q == IN_WAIT) begin
            in_data_d = port_in_data;
            ack_d     = 1'b1;
          end else begin
            out_valid_d = 1'b0;
          end
        end else if (expire) begin
          state_d     = DONE;
          out_valid_d = 1'b0;
          ack_d       = 1'b0;
          if (state_q == IN_WAIT) in_data_d = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Setting the sticky error outranks a simultaneous clear.
    if (expire && !hs)  timeout_d = 1'b1;
    else if (clr_err)   timeout_d = 1'b0;
  end

  assign io_stall       = (state_q == IN_WAIT) || (state_q == OUT_WAIT) ||
                          ((state_q == IDLE) && (ex_in_req || ex_out_req));
  assign io_done        = (state_q == DONE);
  assign port_in_ack    = (state_q == DONE) && ack_q;
  assign in_data        = in_data_q;
  assign io_timeout     = timeout_q;
  assign port_out_valid = out_valid_q;
  assign port_out_data  = out_data_q;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Bench for io_port_ctrl: two instances (long and short timeout) driven by shared stimulus,
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_io_port_ctrl;
  localparam int TO0 = 15;
  localparam int TO1 = 4;

  int to_v [2] = '{TO0, TO1};

  logic       clk = 1'b0;
  logic       reset, ex_in_req, ex_out_req, clr_err, port_in_valid, port_out_ready;
  logic [7:0] ex_out_data, port_in_data;
  logic [7:0] in_data [2];
  logic [7:0] port_out_data [2];
  logic       io_stall [2];
  logic       io_done [2];
  logic       io_timeout [2];
  logic       port_in_ack [2];
  logic       port_out_valid [2];

  always #5 clk = ~clk;

  io_port_ctrl #(.DATA_W(8), .TIMEOUT(TO0)) u0 (
    .clk(clk), .reset(reset), .ex_in_req(ex_in_req), .ex_out_req(ex_out_req),
    .ex_out_data(ex_out_data), .in_data(in_data[0]), .io_stall(io_stall[0]),
    .io_done(io_done[0]), .io_timeout(io_timeout[0]), .clr_err(clr_err),
    .port_in_valid(port_in_valid), .port_in_data(port_in_data), .port_in_ack(port_in_ack[0]),
    .port_out_valid(port_out_valid[0]), .port_out_data(port_out_data[0]),
    .port_out_ready(port_out_ready));

  io_port_ctrl #(.DATA_W(8), .TIMEOUT(TO1)) u1 (
    .clk(clk), .reset(reset), .ex_in_req(ex_in_req), .ex_out_req(ex_out_req),
    .ex_out_data(ex_out_data), .in_data(in_data[1]), .io_stall(io_stall[1]),
    .io_done(io_done[1]), .io_timeout(io_timeout[1]), .clr_err(clr_err),
    .port_in_valid(port_in_valid), .port_in_data(port_in_data), .port_in_ack(port_in_ack[1]),
    .port_out_valid(port_out_valid[1]), .port_out_data(port_out_data[1]),
    .port_out_ready(port_out_ready));

  // Model: active transfer kind (0 none, 1 IN, 2 OUT), wait cycles spent, retiring flag.
  int         m_kind [2];
  int         m_age [2];
  bit         m_fin [2];
  bit         m_ack [2];
  bit         m_ov [2];
  bit         m_err [2];
  logic [7:0] m_in [2];
  logic [7:0] m_od [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit ack_seen = 1'b0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h exp=%0h cyc=%0d", nm, i, act, exp, cyc);
    end
  endtask

  task automatic sample();
    logic st;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      st = (m_kind[i] != 0) || (!m_fin[i] && (ex_in_req || ex_out_req));
      chk("io_stall", i, io_stall[i], st);
      chk("io_done", i, io_done[i], m_fin[i]);
      chk("port_in_ack", i, port_in_ack[i], m_fin[i] && m_ack[i]);
      chk("in_data", i, in_data[i], m_in[i]);
      chk("io_timeout", i, io_timeout[i], m_err[i]);
      chk("port_out_valid", i, port_out_valid[i], m_ov[i]);
      chk("port_out_data", i, port_out_data[i], m_od[i]);
    end
    ack_seen = (m_fin[0] && m_ack[0]) || (m_fin[1] && m_ack[1]);
  endtask

  task automatic step();
    bit hs, set;
    for (int i = 0; i < 2; i++) begin
      set = 1'b0;
      if (reset) begin
        m_kind[i] = 0; m_age[i] = 0; m_fin[i] = 0; m_ack[i] = 0;
        m_ov[i] = 0; m_in[i] = 8'h00; m_od[i] = 8'h00;
      end else if (m_fin[i]) begin
        m_fin[i] = 0; m_ack[i] = 0;
      end else if (m_kind[i] == 0) begin
        if (ex_in_req) begin
          m_kind[i] = 1; m_age[i] = 0;
        end else if (ex_out_req) begin
          m_kind[i] = 2; m_age[i] = 0; m_od[i] = ex_out_data; m_ov[i] = 1;
        end
      end else begin
        hs = (m_kind[i] == 1) ? port_in_valid : (m_ov[i] && port_out_ready);
        if (hs) begin
          if (m_kind[i] == 1) begin m_in[i] = port_in_data; m_ack[i] = 1; end
          else m_ov[i] = 0;
          m_kind[i] = 0; m_fin[i] = 1;
        end else if (to_v[i] != 0 && m_age[i] == to_v[i] - 1) begin
          if (m_kind[i] == 1) m_in[i] = 8'h00;
          m_ov[i] = 0; m_ack[i] = 0; m_kind[i] = 0; m_fin[i] = 1; set = 1'b1;
        end else begin
          m_age[i]++;
        end
      end
      if (reset)        m_err[i] = 0;
      else if (set)     m_err[i] = 1;
      else if (clr_err) m_err[i] = 0;
    end
  endtask

  task automatic advance();
    step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  initial begin
    int ov_cnt;
    int dc [$];

    for (int i = 0; i < 2; i++) begin
      m_kind[i] = 0; m_age[i] = 0; m_fin[i] = 0; m_ack[i] = 0;
      m_ov[i] = 0; m_err[i] = 0; m_in[i] = 8'h00; m_od[i] = 8'h00;
    end
    reset = 1; ex_in_req = 0; ex_out_req = 0; clr_err = 0; ex_out_data = 8'h00;
    port_in_valid = 0; port_in_data = 8'h00; port_out_ready = 0;
    @(posedge clk); #1;

    // Reset state
    sample();
    chk("rst_in_data", 0, in_data[0], 8'h00);
    chk("rst_out_data", 0, port_out_data[0], 8'h00);
    chk("rst_out_valid", 0, port_out_valid[0], 1'b0);
    chk("rst_timeout", 0, io_timeout[0], 1'b0);
    chk("rst_done", 0, io_done[0], 1'b0);
    advance();
    reset = 0;
    tick();

    // IN transfer, device answers on the second cycle
    ex_in_req = 1;
    sample(); chk("in_stall_idle", 0, io_stall[0], 1'b1); advance();
    port_in_valid = 1; port_in_data = 8'hA5;
    tick();
    sample();
    chk("in_data_A5", 0, in_data[0], 8'hA5);
    chk("in_ack", 0, port_in_ack[0], 1'b1);
    chk("in_done", 0, io_done[0], 1'b1);
    chk("in_stall_done", 0, io_stall[0], 1'b0);
    chk("model_in", 0, m_in[0], 8'hA5);
    advance();
    ex_in_req = 0; port_in_valid = 0;
    tick();

    // OUT transfer, ready low for four wait cycles
    ex_out_req = 1; ex_out_data = 8'h3C; port_out_ready = 0;
    ov_cnt = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) port_out_ready = 1;
      sample();
      ov_cnt += int'(port_out_valid[0]);
      chk("out_stall", 0, io_stall[0], 1'b1);
      advance();
    end
    sample();
    chk("out_done", 0, io_done[0], 1'b1);
    chk("out_valid_dropped", 0, port_out_valid[0], 1'b0);
    chk("out_data_3C", 0, port_out_data[0], 8'h3C);
    chk("out_stall_done", 0, io_stall[0], 1'b0);
    advance();
    chk("out_valid_cycles", 0, ov_cnt, 5);
    ex_out_req = 0; port_out_ready = 0;
    for (int k = 0; k < 6; k++) tick();

    // Both requests: IN wins, OUT never starts
    reset = 1; tick(); reset = 0; tick();
    ex_in_req = 1; ex_out_req = 1; ex_out_data = 8'h77;
    tick();
    sample(); chk("both_no_out", 0, port_out_valid[0], 1'b0); advance();
    port_in_valid = 1; port_in_data = 8'h5A;
    tick();
    sample();
    chk("both_in_data", 0, in_data[0], 8'h5A);
    chk("both_out_data", 0, port_out_data[0], 8'h00);
    advance();
    ex_in_req = 0; ex_out_req = 0; port_in_valid = 0;
    tick();

    // Timeout on the short-timeout instance, clear arriving in the timeout cycle
    reset = 1; tick(); reset = 0; tick();
    ex_in_req = 1; tick();
    port_in_valid = 1; port_in_data = 8'hC3; tick();
    ex_in_req = 0; tick();
    port_in_valid = 0; tick();
    chk("pre_to_in_data", 1, in_data[1], 8'hC3);
    ex_in_req = 1; tick();
    for (int k = 0; k < 4; k++) begin
      clr_err = (k == 3);
      sample();
      chk("to_wait_done", 1, io_done[1], 1'b0);
      chk("to_wait_stall", 1, io_stall[1], 1'b1);
      advance();
    end
    clr_err = 0;
    sample();
    chk("to_done", 1, io_done[1], 1'b1);
    chk("to_in_data", 1, in_data[1], 8'h00);
    chk("to_no_ack", 1, port_in_ack[1], 1'b0);
    chk("to_flag", 1, io_timeout[1], 1'b1);
    chk("model_err", 1, m_err[1], 1'b1);
    advance();
    ex_in_req = 0;
    port_in_valid = 1; port_in_data = 8'h11; tick();
    port_in_valid = 0; tick();
    tick();
    chk("to_sticky", 1, io_timeout[1], 1'b1);
    clr_err = 1; tick(); clr_err = 0;
    sample(); chk("to_cleared", 1, io_timeout[1], 1'b0); advance();

    // Reset in the middle of an OUT wait
    ex_out_req = 1; ex_out_data = 8'h99; port_out_ready = 0;
    tick(); tick();
    reset = 1;
    sample(); chk("rm_valid_before", 0, port_out_valid[0], 1'b1); advance();
    reset = 0; ex_out_req = 0;
    sample();
    chk("rm_valid_after", 0, port_out_valid[0], 1'b0);
    chk("rm_no_done", 0, io_done[0], 1'b0);
    advance();
    for (int k = 0; k < 3; k++) tick();

    // Back-to-back OUTs with ready held high
    ex_out_req = 1; ex_out_data = 8'hD1; port_out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) ex_out_data = 8'hD2;
      sample();
      if (io_done[0]) dc.push_back(cyc);
      if (k == 2) chk("b2b_data1", 0, port_out_data[0], 8'hD1);
      if (k == 5) chk("b2b_data2", 0, port_out_data[0], 8'hD2);
      advance();
    end
    ex_out_req = 0; port_out_ready = 0;
    chk("b2b_pulses", 0, dc.size(), 2);
    if (dc.size() == 2) chk("b2b_spacing", 0, dc[1] - dc[0], 3);
    tick();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      reset          = ($urandom_range(0, 63) == 0);
      ex_in_req      = ($urandom_range(0, 3) == 0);
      ex_out_req     = ($urandom_range(0, 3) == 0);
      ex_out_data    = 8'($urandom);
      port_in_data   = 8'($urandom);
      port_in_valid  = ack_seen ? 1'b0 : ($urandom_range(0, 4) == 0);
      port_out_ready = ($urandom_range(0, 2) == 0);
      clr_err        = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
